// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : EX-stage multiply/divide unit port bundle. The pipeline side
//               (master) drives the launch request, operands and read select.
//               The unit (slave) returns busy and the HI/LO state.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    // Pipeline side: issues operations and reads results
    modport master (
        output start,
        output md_op,
        output src_a,
        output src_b,
        output rd_sel,
        input  busy,
        input  hi,
        input  lo,
        input  md_out
    );

    // Unit side: consumes operations, owns HI/LO
    modport slave (
        input  start,
        input  md_op,
        input  src_a,
        input  src_b,
        input  rd_sel,
        output busy,
        output hi,
        output lo,
        output md_out
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multiply/divide unit of the EX stage. The result is computed
//               in the start cycle and held in a staging register. HI/LO are
//               updated only after a fixed busy latency, which matches the
//               timing of an iterative unit. mthi/mtlo write HI/LO directly
//               while the unit is idle.
//               Optional feature macro: MDU_MADD_EN enables the
//               madd/maddu/msub/msubu accumulate ops (codes 7-10).
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);

    // Latencies below 1 would never reach the commit edge, so clamp them
    localparam int c_mult_cycles = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
    localparam int c_div_cycles  = (DIV_CYCLES  < 1) ? 1 : DIV_CYCLES;
    localparam int c_cnt_max     = (c_mult_cycles > c_div_cycles) ? c_mult_cycles : c_div_cycles;
    localparam int c_cnt_w       = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(c_mult_cycles);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(c_div_cycles);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [63:0]         r_stage;
    logic [63:0]         w_stage_nxt;
    logic                r_commit;      // 0 when HI/LO must survive (divide by zero)
    logic                w_commit_nxt;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         w_hi_nxt;
    logic [31:0]         w_lo_nxt;

    // Operation decode
    logic w_is_mult;
    logic w_is_div;
    logic w_is_signed;
`ifdef MDU_MADD_EN
    logic w_is_acc;
    logic w_is_sub;
`endif

    // Datapath
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [63:0] w_mult_res;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Classify md_op into launch class and signedness; unknown codes decode to nothing
    always_comb begin
        w_is_mult   = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
`ifdef MDU_MADD_EN
        w_is_acc    = 1'b0;
        w_is_sub    = 1'b0;
`endif
        case (bus.md_op)
            c_op_mult:  begin w_is_mult = 1'b1; w_is_signed = 1'b1; end
            c_op_multu: begin w_is_mult = 1'b1; end
            c_op_div:   begin w_is_div  = 1'b1; w_is_signed = 1'b1; end
            c_op_divu:  begin w_is_div  = 1'b1; end
`ifdef MDU_MADD_EN
            c_op_madd:  begin w_is_mult = 1'b1; w_is_acc = 1'b1; w_is_signed = 1'b1; end
            c_op_maddu: begin w_is_mult = 1'b1; w_is_acc = 1'b1; end
            c_op_msub:  begin w_is_mult = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1; w_is_signed = 1'b1; end
            c_op_msubu: begin w_is_mult = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1; end
`endif
            default:    ;
        endcase
    end

    // 64-bit product: the low 64 bits of the extended operands are exact for both signednesses
    always_comb begin
        w_a_ext = w_is_signed ? {{32{bus.src_a[31]}}, bus.src_a} : {32'd0, bus.src_a};
        w_b_ext = w_is_signed ? {{32{bus.src_b[31]}}, bus.src_b} : {32'd0, bus.src_b};
        w_prod  = w_a_ext * w_b_ext;
`ifdef MDU_MADD_EN
        if (w_is_acc) begin
            w_mult_res = w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        end else begin
            w_mult_res = w_prod;
        end
`else
        w_mult_res = w_prod;
`endif
    end

    // Sign-magnitude divide: quotient truncates toward zero, remainder follows dividend.
    // 0x80000000 / -1 falls out naturally as magnitude 0x80000000 negated to itself.
    always_comb begin
        w_a_neg  = w_is_signed & bus.src_a[31];
        w_b_neg  = w_is_signed & bus.src_b[31];
        w_b_zero = (bus.src_b == 32'd0);
        w_a_mag  = w_a_neg ? (~bus.src_a + 32'd1) : bus.src_a;
        w_b_mag  = w_b_neg ? (~bus.src_b + 32'd1) : bus.src_b;
        w_den    = w_b_zero ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_den;
        w_r_mag  = w_a_mag % w_den;
        w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    end

    // Next-state logic: launch from IDLE, count down in RUN, commit on the final edge
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stage_nxt  = r_stage;
        w_commit_nxt = r_commit;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && w_is_mult) begin
                    w_state_nxt  = ST_RUN;
                    w_cnt_nxt    = c_mult_load;
                    w_stage_nxt  = w_mult_res;
                    w_commit_nxt = 1'b1;
                end else if (bus.start && w_is_div) begin
                    w_state_nxt  = ST_RUN;
                    w_cnt_nxt    = c_div_load;
                    w_stage_nxt  = {w_rem, w_quot};
                    w_commit_nxt = ~w_b_zero;
                end
                // Move-to ops need no start pulse and are only honoured when idle
                if (bus.md_op == c_op_mthi) begin
                    w_hi_nxt = bus.src_a;
                end
                if (bus.md_op == c_op_mtlo) begin
                    w_lo_nxt = bus.src_a;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt <= c_cnt_one) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (r_commit) begin
                        w_hi_nxt = r_stage[63:32];
                        w_lo_nxt = r_stage[31:0];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset clears everything, aborting any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_stage  <= '0;
            r_commit <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stage  <= w_stage_nxt;
            r_commit <= w_commit_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign bus.busy   = (r_state == ST_RUN);
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.md_out = bus.rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Scoreboard bench for md_unit. Each launch pushes its
//               expected HI/LO and busy length into a queue. A monitor pops
//               the queue on every busy falling edge that is not caused by
//               reset. Idle-time behaviour is checked inline.
//               Honours MDU_MADD_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    md_unit_if bus();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;
    logic mon_prev;
    int   mon_cnt;
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse; the operands are scrambled afterwards to show they were sampled once
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                          input int cyc, input string name);
        exp_t e;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.cycles = cyc; e.name = name;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.src_a = 32'hA5A5_A5A5;
        bus.src_b = 32'h5A5A_5A5A;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Monitor: a busy falling edge outside reset is a commit; compare against the queue head
    initial begin
        mon_prev = 1'b0;
        mon_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                mon_prev = 1'b0;
                mon_cnt  = 0;
            end else if (bus.busy === 1'b1) begin
                mon_prev = 1'b1;
                mon_cnt++;
            end else begin
                if (mon_prev) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_commit: hi=%h lo=%h, expected no operation", bus.hi, bus.lo);
                    end else begin
                        mon_e = sb.pop_front();
                        chk({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                        chk({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                        chk({mon_e.name, "_busy_cycles"}, 32'(mon_cnt), 32'(mon_e.cycles));
                    end
                end
                mon_prev = 1'b0;
                mon_cnt  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.md_op  = 4'd0;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.rd_sel = 1'b0;
        tick();
        tick();
        chk("reset_busy",   32'(bus.busy), 32'd0);
        chk("reset_hi",     bus.hi,        32'd0);
        chk("reset_lo",     bus.lo,        32'd0);
        chk("reset_md_out", bus.md_out,    32'd0);
        reset = 1'b0;

        // Multiply and divide results, including the signed boundary cases
        launch(4'd1, 32'hFFFF_FFFE, 32'd3,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  "mult");
        wait_idle("mult");
        launch(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 5,  "multu");
        wait_idle("multu");
        launch(4'd3, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
        wait_idle("div");
        launch(4'd4, 32'd7,         32'd0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "divu_by_zero");
        wait_idle("divu_by_zero");
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 10, "div_overflow");
        wait_idle("div_overflow");
        launch(4'd3, 32'd7,         32'hFFFF_FFFE, 1, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_neg_divisor");
        wait_idle("div_neg_divisor");
        launch(4'd4, 32'd100,       32'd7,         1, 32'h0000_0002, 32'h0000_000E, 10, "divu");
        wait_idle("divu");

        // mthi / mtlo while idle
        bus.md_op  = 4'd5;
        bus.src_a  = 32'h1234_5678;
        bus.rd_sel = 1'b1;
        tick();
        bus.md_op  = 4'd0;
        chk("mthi_hi",      bus.hi,     32'h1234_5678);
        chk("mthi_md_out",  bus.md_out, 32'h1234_5678);
        chk("mthi_lo_keep", bus.lo,     32'h0000_000E);
        bus.md_op  = 4'd6;
        bus.src_a  = 32'hCAFE_F00D;
        bus.rd_sel = 1'b0;
        tick();
        bus.md_op  = 4'd0;
        chk("mtlo_lo",      bus.lo,     32'hCAFE_F00D);
        chk("mtlo_md_out",  bus.md_out, 32'hCAFE_F00D);

        // mtlo and a second start during RUN must both be ignored
        launch(4'd1, 32'd3, 32'd4, 1, 32'h0000_0000, 32'h0000_000C, 5, "mult_run_ignore");
        bus.md_op = 4'd6;
        bus.src_a = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b1;
        bus.md_op = 4'd3;
        bus.src_a = 32'd100;
        bus.src_b = 32'd3;
        tick();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        wait_idle("mult_run_ignore");

        // start with non-launching codes
        bus.start = 1'b1;
        bus.md_op = 4'd0;
        bus.src_a = 32'h1111_1111;
        bus.src_b = 32'd1;
        tick();
        bus.start = 1'b0;
        chk("op_none_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.md_op = 4'd15;
        tick();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        chk("op_unknown_busy", 32'(bus.busy), 32'd0);
        chk("op_unknown_hi",   bus.hi, 32'h0000_0000);
        chk("op_unknown_lo",   bus.lo, 32'h0000_000C);

        // Reset during the third busy cycle aborts without commit
        launch(4'd1, 32'd5, 32'd5, 0, 32'd0, 32'd0, 0, "abort");
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi",   bus.hi, 32'd0);
        chk("abort_lo",   bus.lo, 32'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("post_abort_busy", 32'(bus.busy), 32'd0);
        chk("post_abort_hi",   bus.hi, 32'd0);
        chk("post_abort_lo",   bus.lo, 32'd0);

        // Accumulate ops: hi=0, lo=10, then madd -1*3
        bus.md_op = 4'd6;
        bus.src_a = 32'd10;
        tick();
        bus.md_op = 4'd0;
        chk("madd_pre_lo", bus.lo, 32'd10);
`ifdef MDU_MADD_EN
        launch(4'd7,  32'hFFFF_FFFF, 32'd3, 1, 32'h0000_0000, 32'h0000_0007, 5, "madd");
        wait_idle("madd");
        launch(4'd10, 32'd2,         32'd3, 1, 32'h0000_0000, 32'h0000_0001, 5, "msubu");
        wait_idle("msubu");
        launch(4'd9,  32'd2,         32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 5, "msub");
        wait_idle("msub");
`else
        bus.start = 1'b1;
        bus.md_op = 4'd7;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'd3;
        tick();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        chk("madd_off_busy", 32'(bus.busy), 32'd0);
        repeat (6) tick();
        chk("madd_off_busy_late", 32'(bus.busy), 32'd0);
        chk("madd_off_hi", bus.hi, 32'd0);
        chk("madd_off_lo", bus.lo, 32'd10);
`endif

        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
